fanout_ack_scheduler: RTL

Sequential fanout controller for the CGRA interconnect: accepts one token from a single upstream producer and delivers it to every configured downstream consumer. Each consumer may accept on a different cycle. The upstream token is released only once all configured consumers have taken it. It replaces a purely combinational all-consumers-ready join, so a slow consumer no longer blocks consumers that are already ready.

---
 rtl/fanout_ack_scheduler.sv | 76 +++++++
 1 files changed

// File: rtl/fanout_ack_scheduler.sv
// Fanout of one upstream token to every masked consumer; each consumer handshakes independently.
// Latency 1 cycle capture-to-out_valid; upstream stalls until all masked consumers accept (in_ready comb from out_ready).
module fanout_ack_scheduler #(
  parameter int NUM_OUT     = 9,
  parameter int DATA_WIDTH  = 16,
  parameter int STALL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_OUT-1:0]     cfg_mask,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic [NUM_OUT-1:0]     out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic [NUM_OUT-1:0]     out_ready,
  output logic [NUM_OUT-1:0]     pending,
  output logic                   busy,
  output logic [STALL_WIDTH-1:0] stall_cycles
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state;
  logic [NUM_OUT-1:0]     pend_q;
  logic [DATA_WIDTH-1:0]  data_q;
  logic [STALL_WIDTH-1:0] stall_q;

  logic               hold;
  logic               drain;
  logic               capture;
  logic [NUM_OUT-1:0] acc;

  assign hold      = (state == HOLD);
  assign out_valid = hold ? pend_q : '0;
  assign acc       = out_valid & out_ready;
  // Every still-pending consumer is ready, so the slot frees up this very cycle.
  assign drain     = hold && ((pend_q & ~out_ready) == '0);
  assign in_ready  = !flush && (!hold || drain);
  assign capture   = in_valid && in_ready;

  assign out_data     = data_q;
  assign pending      = pend_q;
  assign busy         = hold;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend_q  <= '0;
      data_q  <= '0;
      stall_q <= '0;
    end else if (flush) begin
      state   <= IDLE;
      pend_q  <= '0;
      stall_q <= '0;
    end else if (capture) begin
      // A zero mask still loads the data register but never raises out_valid.
      data_q  <= in_data;
      pend_q  <= cfg_mask;
      stall_q <= '0;
      state   <= (cfg_mask != '0) ? HOLD : IDLE;
    end else if (hold) begin
      if (drain) begin
        pend_q <= '0;
        state  <= IDLE;
      end else begin
        pend_q <= pend_q & ~acc;
      end
      if ((acc == '0) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
    end
  end

endmodule
